stack_unit: RTL and testbench

- Self-contained hardware LIFO stack: owns its stack pointer, single clock, registered pop data.
- Successor to the externally-pointed data stack. Adds a parametrised depth and width, full/empty flags, a replace-top mode, and sticky overflow/underflow error flags.
- Sits beside the register file; serves the CPU's PUSH/POP/call-frame instructions.

---
 rtl/stack_pkg.sv | 16 +
 rtl/stack_ram.sv | 26 ++
 rtl/stack_unit.sv | 166 ++++++++++++++++
 tb/tb_stack_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the hardware LIFO stack: op encodings and default sizing.
package stack_pkg;

  // Two-bit stack operation codes presented on stackOp.
  typedef enum logic [1:0] {
    STACK_NOP     = 2'b00,
    STACK_PUSH    = 2'b01,
    STACK_POP     = 2'b10,
    STACK_REPLACE = 2'b11
  } stack_op_e;

  // Default word width and log2 depth.
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_STACK_BITS = 12;

endpackage : stack_pkg

// File: rtl/stack_ram.sv
// Single-port synchronous stack storage. Read-first: rdata returns the word
// held at addr before any write performed at the same edge.
module stack_ram #(
  parameter int unsigned DATA_WIDTH = stack_pkg::DEFAULT_DATA_WIDTH,
  parameter int unsigned STACK_BITS = stack_pkg::DEFAULT_STACK_BITS
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [STACK_BITS-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** STACK_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Registered read of the old contents alongside an optional write.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule : stack_ram

// File: rtl/stack_unit.sv
// Self-contained LIFO stack: owns the pointer, full/empty flags, sticky
// overflow/underflow flags and a registered pop/replace data output.
module stack_unit
  import stack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned STACK_BITS = DEFAULT_STACK_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            stackOp,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  errClear,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  output logic [STACK_BITS:0]   stackPointer,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  // Entry count when every slot is occupied (DEPTH).
  localparam logic [STACK_BITS:0] DEPTH_COUNT = {1'b1, {STACK_BITS{1'b0}}};

  stack_op_e             op;
  logic [STACK_BITS:0]   stack_ptr;
  logic [STACK_BITS:0]   ptr_next;
  logic [STACK_BITS-1:0] top_addr;
  logic [STACK_BITS-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  do_push;
  logic                  do_pop;
  logic                  do_replace;
  logic                  overflow_event;
  logic                  underflow_event;
  logic                  read_valid;
  logic                  out_from_ram;
  logic [DATA_WIDTH-1:0] held_data;
  logic                  overflow_q;
  logic                  underflow_q;

  assign op = stack_op_e'(stackOp);

  assign empty        = (stack_ptr == '0);
  assign full         = (stack_ptr == DEPTH_COUNT);
  assign stackPointer = stack_ptr;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Truncating to STACK_BITS also maps a full pointer onto the last slot.
  assign top_addr = STACK_BITS'(stack_ptr - 1'b1);

  // Op decode: resolve each op against the current full/empty state.
  always_comb begin
    do_push         = 1'b0;
    do_pop          = 1'b0;
    do_replace      = 1'b0;
    overflow_event  = 1'b0;
    underflow_event = 1'b0;
    unique case (op)
      STACK_NOP: begin
      end
      STACK_PUSH: begin
        if (full) begin
          overflow_event = 1'b1;
        end else begin
          do_push = 1'b1;
        end
      end
      STACK_POP: begin
        if (empty) begin
          underflow_event = 1'b1;
        end else begin
          do_pop = 1'b1;
        end
      end
      STACK_REPLACE: begin
        if (empty) begin
          underflow_event = 1'b1;
          do_push         = 1'b1;
        end else begin
          do_replace = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign read_valid = do_pop || do_replace;

  // RAM control and next pointer value.
  always_comb begin
    ram_we   = (do_push || do_replace) && !reset;
    ram_addr = read_valid ? top_addr : stack_ptr[STACK_BITS-1:0];
    ptr_next = stack_ptr;
    if (do_push) begin
      ptr_next = stack_ptr + 1'b1;
    end else if (do_pop) begin
      ptr_next = stack_ptr - 1'b1;
    end
  end

  stack_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .STACK_BITS(STACK_BITS)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(data),
    .rdata(ram_rdata)
  );

  // Pointer register.
  always_ff @(posedge clock) begin
    if (reset) begin
      stack_ptr <= '0;
    end else begin
      stack_ptr <= ptr_next;
    end
  end

  // Sticky error flags: a same-cycle error event beats errClear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (overflow_event) begin
        overflow_q <= 1'b1;
      end else if (errClear) begin
        overflow_q <= 1'b0;
      end
      if (underflow_event) begin
        underflow_q <= 1'b1;
      end else if (errClear) begin
        underflow_q <= 1'b0;
      end
    end
  end

  // Output registers. The RAM's own read register supplies the popped word;
  // held_data re-captures the visible word every edge so dataOut stays put
  // on cycles that do not read, and is forced to zero on reset/empty POP.
  always_ff @(posedge clock) begin
    if (reset) begin
      dataValid    <= 1'b0;
      out_from_ram <= 1'b0;
      held_data    <= '0;
    end else begin
      dataValid    <= read_valid;
      out_from_ram <= read_valid;
      if (op == STACK_POP && empty) begin
        held_data <= '0;
      end else begin
        held_data <= dataOut;
      end
    end
  end

  assign dataOut = out_from_ram ? ram_rdata : held_data;

endmodule : stack_unit

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit (16-bit words, depth 4).
module tb_stack_unit;
  import stack_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned SB = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    stackOp;
  logic [DW-1:0] data;
  logic          errClear;
  logic [DW-1:0] dataOut;
  logic          dataValid;
  logic [SB:0]   stackPointer;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  stack_unit #(
    .DATA_WIDTH(DW),
    .STACK_BITS(SB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .stackOp     (stackOp),
    .data        (data),
    .errClear    (errClear),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .stackPointer(stackPointer),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clock = ~clock;

  // Present one op for one clock edge, then return to NOP; outputs are
  // sampled 1ns after the edge by the caller.
  task automatic step(input stack_op_e op, input logic [DW-1:0] d, input logic clr);
    stackOp  = op;
    data     = d;
    errClear = clr;
    @(posedge clock);
    #1;
    stackOp  = STACK_NOP;
    errClear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(STACK_NOP, '0, 1'b0);
    step(STACK_NOP, '0, 1'b0);
    reset = 1'b0;
    checks++; if (stackPointer !== 3'd0) begin errors++; $display("FAIL reset_sp got %0d exp 0", stackPointer); end
    checks++; if (dataOut !== 16'h0) begin errors++; $display("FAIL reset_dataOut got %h exp 0000", dataOut); end
    checks++; if (dataValid !== 1'b0) begin errors++; $display("FAIL reset_dataValid got %b exp 0", dataValid); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %b%b exp 10", empty, full); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", overflow, underflow); end
  endtask

  task automatic test_push_pop();
    logic [DW-1:0] vals [3];
    vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033;
    for (int i = 0; i < 3; i++) begin
      step(STACK_PUSH, vals[i], 1'b0);
      checks++; if (stackPointer !== 3'(i + 1)) begin errors++; $display("FAIL push_sp%0d got %0d exp %0d", i, stackPointer, i + 1); end
      checks++; if (dataValid !== 1'b0) begin errors++; $display("FAIL push_dv%0d got %b exp 0", i, dataValid); end
    end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL push_empty got %b exp 0", empty); end
    for (int i = 0; i < 3; i++) begin
      step(STACK_POP, '0, 1'b0);
      checks++; if (dataOut !== vals[2 - i]) begin errors++; $display("FAIL pop_data%0d got %h exp %h", i, dataOut, vals[2 - i]); end
      checks++; if (dataValid !== 1'b1) begin errors++; $display("FAIL pop_dv%0d got %b exp 1", i, dataValid); end
      checks++; if (stackPointer !== 3'(2 - i)) begin errors++; $display("FAIL pop_sp%0d got %0d exp %0d", i, stackPointer, 2 - i); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pop_empty got %b exp 1", empty); end
    step(STACK_NOP, '0, 1'b0);
    checks++; if (dataValid !== 1'b0) begin errors++; $display("FAIL nop_dv got %b exp 0", dataValid); end
    checks++; if (dataOut !== 16'h0011) begin errors++; $display("FAIL nop_hold got %h exp 0011", dataOut); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] vals [5];
    vals[0] = 16'h1001; vals[1] = 16'h2002; vals[2] = 16'h3003;
    vals[3] = 16'h4004; vals[4] = 16'h5005;
    for (int i = 0; i < 4; i++) begin
      step(STACK_PUSH, vals[i], 1'b0);
    end
    checks++; if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL ovf_full got full=%b empty=%b exp 1 0", full, empty); end
    checks++; if (stackPointer !== 3'd4) begin errors++; $display("FAIL ovf_sp4 got %0d exp 4", stackPointer); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow); end
    step(STACK_PUSH, vals[4], 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if (stackPointer !== 3'd4) begin errors++; $display("FAIL ovf_sp_hold got %0d exp 4", stackPointer); end
    step(STACK_POP, '0, 1'b0);
    checks++; if (dataOut !== 16'h4004) begin errors++; $display("FAIL ovf_pop got %h exp 4004", dataOut); end
    checks++; if (full !== 1'b0 || stackPointer !== 3'd3) begin errors++; $display("FAIL ovf_after_pop got full=%b sp=%0d exp 0 3", full, stackPointer); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    step(STACK_NOP, '0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    for (int i = 0; i < 3; i++) begin
      step(STACK_POP, '0, 1'b0);
      checks++; if (dataOut !== vals[2 - i]) begin errors++; $display("FAIL ovf_drain%0d got %h exp %h", i, dataOut, vals[2 - i]); end
    end
  endtask

  task automatic test_underflow();
    step(STACK_POP, '0, 1'b0);
    checks++; if (dataOut !== 16'h0) begin errors++; $display("FAIL unf_data got %h exp 0000", dataOut); end
    checks++; if (dataValid !== 1'b0) begin errors++; $display("FAIL unf_dv got %b exp 0", dataValid); end
    checks++; if (underflow !== 1'b1 || stackPointer !== 3'd0) begin errors++; $display("FAIL unf_flag got unf=%b sp=%0d exp 1 0", underflow, stackPointer); end
    step(STACK_NOP, '0, 1'b1);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got %b exp 0", underflow); end
    step(STACK_POP, '0, 1'b1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_event_wins got %b exp 1", underflow); end
    step(STACK_NOP, '0, 1'b1);
  endtask

  task automatic test_replace();
    step(STACK_PUSH, 16'hAAAA, 1'b0);
    step(STACK_REPLACE, 16'hBBBB, 1'b0);
    checks++; if (dataOut !== 16'hAAAA) begin errors++; $display("FAIL repl_data got %h exp aaaa", dataOut); end
    checks++; if (dataValid !== 1'b1) begin errors++; $display("FAIL repl_dv got %b exp 1", dataValid); end
    checks++; if (stackPointer !== 3'd1) begin errors++; $display("FAIL repl_sp got %0d exp 1", stackPointer); end
    step(STACK_POP, '0, 1'b0);
    checks++; if (dataOut !== 16'hBBBB) begin errors++; $display("FAIL repl_pop got %h exp bbbb", dataOut); end
    checks++; if (stackPointer !== 3'd0) begin errors++; $display("FAIL repl_pop_sp got %0d exp 0", stackPointer); end
  endtask

  task automatic test_replace_empty();
    step(STACK_REPLACE, 16'h0077, 1'b0);
    checks++; if (stackPointer !== 3'd1) begin errors++; $display("FAIL repl_empty_sp got %0d exp 1", stackPointer); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL repl_empty_unf got %b exp 1", underflow); end
    checks++; if (dataValid !== 1'b0) begin errors++; $display("FAIL repl_empty_dv got %b exp 0", dataValid); end
    step(STACK_POP, '0, 1'b0);
    checks++; if (dataOut !== 16'h0077 || dataValid !== 1'b1) begin errors++; $display("FAIL repl_empty_pop got %h/%b exp 0077/1", dataOut, dataValid); end
    step(STACK_NOP, '0, 1'b1);
  endtask

  task automatic test_back_to_back();
    step(STACK_PUSH, 16'h5A5A, 1'b0);
    step(STACK_POP, '0, 1'b0);
    checks++; if (dataOut !== 16'h5A5A || dataValid !== 1'b1) begin errors++; $display("FAIL b2b_pop got %h/%b exp 5a5a/1", dataOut, dataValid); end
    step(STACK_PUSH, 16'hC3C3, 1'b0);
    checks++; if (dataValid !== 1'b0 || dataOut !== 16'h5A5A) begin errors++; $display("FAIL b2b_push_hold got %h/%b exp 5a5a/0", dataOut, dataValid); end
    step(STACK_POP, '0, 1'b0);
    checks++; if (dataOut !== 16'hC3C3) begin errors++; $display("FAIL b2b_pop2 got %h exp c3c3", dataOut); end
  endtask

  task automatic test_reset_mid();
    step(STACK_POP, '0, 1'b0);
    step(STACK_PUSH, 16'h0101, 1'b0);
    step(STACK_PUSH, 16'h0202, 1'b0);
    step(STACK_PUSH, 16'h0303, 1'b0);
    checks++; if (underflow !== 1'b1 || stackPointer !== 3'd3) begin errors++; $display("FAIL mid_setup got unf=%b sp=%0d exp 1 3", underflow, stackPointer); end
    reset = 1'b1;
    step(STACK_POP, '0, 1'b0);
    reset = 1'b0;
    checks++; if (stackPointer !== 3'd0) begin errors++; $display("FAIL mid_sp got %0d exp 0", stackPointer); end
    checks++; if (dataValid !== 1'b0) begin errors++; $display("FAIL mid_dv got %b exp 0", dataValid); end
    checks++; if (dataOut !== 16'h0) begin errors++; $display("FAIL mid_data got %h exp 0000", dataOut); end
    checks++; if (underflow !== 1'b0 || overflow !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL mid_flags got unf=%b ovf=%b empty=%b exp 0 0 1", underflow, overflow, empty); end
    step(STACK_NOP, '0, 1'b0);
    checks++; if (dataValid !== 1'b0) begin errors++; $display("FAIL mid_dv_after got %b exp 0", dataValid); end
  endtask

  initial begin
    reset    = 1'b1;
    stackOp  = STACK_NOP;
    data     = '0;
    errClear = 1'b0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_replace_empty();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_stack_unit
